// File: rtl/ascon_permutation_ctrl.sv
// Iterative Ascon-p[rnd] permutation controller: UNROLL rounds per clock over a registered 320-bit state.
// Optional abort port: define ASCON_PERM_ABORT_EN.

package ascon_perm_pkg;

    // Word k of the packed array is Ascon state word S_k.
    typedef logic [4:0][63:0] ascon_state_t;

    localparam logic [7:0] ROUND_CONST [16] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic ascon_state_t linear_diffusion_layer(input ascon_state_t s);
        ascon_state_t r;
        r[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
        r[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
        r[2] = s[2] ^ ror64(s[2],  1) ^ ror64(s[2],  6);
        r[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
        r[4] = s[4] ^ ror64(s[4],  7) ^ ror64(s[4], 41);
        return r;
    endfunction

    // Bitsliced 5-bit S-box applied to all 64 columns at once; x0 is the column MSB.
    function automatic ascon_state_t substitution_layer(input ascon_state_t s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0] ^ s[4];
        x1 = s[1];
        x2 = s[2] ^ s[1];
        x3 = s[3];
        x4 = s[4] ^ s[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [3:0] idx);
        ascon_state_t t;
        t = s;
        t[2][7:0] = t[2][7:0] ^ ROUND_CONST[idx];
        return linear_diffusion_layer(substitution_layer(t));
    endfunction

endpackage

module ascon_permutation_ctrl
    import ascon_perm_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_valid_i,
    output logic         start_ready_o,
    input  logic [4:0]   rnd_i,
    input  ascon_state_t state_i,
`ifdef ASCON_PERM_ABORT_EN
    input  logic         abort_i,
`endif
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output logic         busy_o,
    output logic         err_o
);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $fatal(1, "ascon_permutation_ctrl: UNROLL must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [4:0] STEP = 5'(UNROLL);

    fsm_e         fsm_q, fsm_d;
    ascon_state_t state_q, state_d;
    ascon_state_t round_state;
    logic [4:0]   idx_q, idx_d;
    logic         err_q, err_d;
    logic         rnd_legal;

    assign rnd_legal = (rnd_i <= 5'd16) && !((UNROLL == 2) && rnd_i[0]);

    // NOTE: a chain inside always_comb uses blocking '=' so each stage sees the previous
    // stage's value in the same evaluation; registers below use '<=' only.
    always_comb begin
        ascon_state_t s;
        s = state_q;
        for (int k = 0; k < UNROLL; k++) begin
            s = ascon_round(s, idx_q[3:0] + 4'(k));
        end
        round_state = s;
    end

    // NOTE: every output of this block gets a default first; a missing assignment on
    // any branch would infer a latch.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start_valid_i) begin
                    if (rnd_legal) begin
                        state_d = state_i;
                        idx_d   = 5'd16 - rnd_i;
                        fsm_d   = (rnd_i == 5'd0) ? DONE : RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                state_d = round_state;
                idx_d   = idx_q + STEP;
                if (idx_q + STEP == 5'd16) fsm_d = DONE;
            end
            DONE: begin
                if (out_ready_i) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
`ifdef ASCON_PERM_ABORT_EN
        // Abort overrides a pending output handshake and wipes the state.
        if (abort_i && fsm_q != IDLE) begin
            fsm_d   = IDLE;
            state_d = '0;
            idx_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign start_ready_o = (fsm_q == IDLE);
    assign out_valid_o   = (fsm_q == DONE);
    assign busy_o        = (fsm_q != IDLE);
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// Scoreboard bench for ascon_permutation_ctrl against a column-table reference model of Ascon-p.
// Abort checks are compiled in when ASCON_PERM_ABORT_EN is defined.

module tb_ascon_permutation_ctrl #(parameter int UNROLL = 1);
    import ascon_perm_pkg::ascon_state_t;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    typedef struct {
        ascon_state_t exp;
        int           rounds;
        int           acc;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_valid_i = 1'b0;
    logic         start_ready_o;
    logic [4:0]   rnd_i = '0;
    ascon_state_t state_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    ascon_state_t state_o;
    logic         busy_o;
    logic         err_o;
    logic         abort_i = 1'b0;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  ready_mode = 0;   // 0 random, 1 held low, 2 held high
    sb_t sb [$];
    logic         prev_valid = 1'b0;
    ascon_state_t held_state = '0;

    ascon_permutation_ctrl #(.UNROLL(UNROLL)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_valid_i(start_valid_i),
        .start_ready_o(start_ready_o),
        .rnd_i        (rnd_i),
        .state_i      (state_i),
`ifdef ASCON_PERM_ABORT_EN
        .abort_i      (abort_i),
`endif
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .state_o      (state_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       out_ready_i = 1'b0;
            2:       out_ready_i = 1'b1;
            default: out_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] round_const(input int i);
        return {4'(3 - i), 4'(12 + i)};
    endfunction

    // Reference: per-column S-box table lookup and per-bit rotation sums.
    function automatic ascon_state_t model_perm(input ascon_state_t s, input int r);
        logic [63:0]  x [5];
        logic [63:0]  y [5];
        logic [4:0]   col;
        ascon_state_t res;
        for (int k = 0; k < 5; k++) x[k] = s[k];
        for (int i = 16 - r; i < 16; i++) begin
            x[2][7:0] = x[2][7:0] ^ round_const(i);
            for (int j = 0; j < 64; j++) begin
                col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                col = SBOX[col];
                for (int k = 0; k < 5; k++) y[k][j] = col[4 - k];
            end
            for (int k = 0; k < 5; k++)
                for (int j = 0; j < 64; j++)
                    x[k][j] = y[k][j] ^ y[k][(j + ROT_A[k]) % 64] ^ y[k][(j + ROT_B[k]) % 64];
        end
        for (int k = 0; k < 5; k++) res[k] = x[k];
        return res;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
        return s;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input ascon_state_t s, input logic [4:0] r, input bit track);
        int           guard;
        bit           legal;
        ascon_state_t prev;
        sb_t          e;
        guard = 0;
        while (!start_ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!start_ready_o) begin
            check("start_ready timeout", start_ready_o, 1'b1);
            return;
        end
        legal = (r <= 5'd16) && ((int'(r) % UNROLL) == 0);
        prev  = state_o;
        start_valid_i = 1'b1;
        rnd_i   = r;
        state_i = s;
        if (legal && track) begin
            e.exp = model_perm(s, int'(r));
            e.rounds = int'(r);
            e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        start_valid_i = 1'b0;
        rnd_i   = 5'($urandom);
        state_i = rand_state();
        check("err_o after accept", err_o, !legal);
        check("busy_o after accept", busy_o, legal);
        if (!legal) begin
            check("state kept on reject", state_o, prev);
            @(negedge clk);
            check("err_o single pulse", err_o, 1'b0);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !start_ready_o) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("drain scoreboard", sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each output handshake.
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid_o) begin
                if (sb.size() == 0) begin
                    if (!prev_valid) check("stray out_valid", out_valid_o, 1'b0);
                end else if (!prev_valid) begin
                    check("latency", cyc - sb[0].acc - 1, sb[0].rounds / UNROLL);
                end else begin
                    check("state_o held", state_o, held_state);
                end
                held_state = state_o;
                if (out_ready_i && !abort_i && sb.size() != 0) begin
                    check("result", state_o, sb[0].exp);
                    void'(sb.pop_front());
                end
            end
            prev_valid = out_valid_o && !out_ready_i;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ascon_state_t s;
        ascon_state_t held;
        logic         seen;
        int           guard;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("reset state_o", state_o, '0);
        check("reset out_valid", out_valid_o, 1'b0);
        check("reset busy", busy_o, 1'b0);
        check("reset err", err_o, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk);
        check("start_ready after reset", start_ready_o, 1'b1);

        // Zero-round pass-through.
        ready_mode = 2;
        s = '0;
        for (int k = 0; k < 5; k++) s[k] = 64'(k + 1);
        issue(s, 5'd0, 1'b1);
        check("p0 out_valid", out_valid_o, 1'b1);
        check("p0 passthrough", state_o, s);
        drain();

        // Standard round counts on the all-zero state.
        issue('0, 5'd12, 1'b1);
        drain();
        issue('0, 5'd8, 1'b1);
        drain();
        issue('0, 5'd6, 1'b1);
        drain();
        issue(rand_state(), 5'd16, 1'b1);
        drain();

        // Back-pressure in DONE.
        ready_mode = 1;
        issue(rand_state(), 5'd4, 1'b1);
        guard = 0;
        while (!out_valid_o && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("bp out_valid rise", out_valid_o, 1'b1);
        held = state_o;
        repeat (10) begin
            @(negedge clk);
            check("bp out_valid", out_valid_o, 1'b1);
            check("bp start_ready", start_ready_o, 1'b0);
            check("bp state_o", state_o, held);
        end
        ready_mode = 2;
        repeat (2) @(negedge clk);
        check("bp idle after release", start_ready_o, 1'b1);
        check("bp busy after release", busy_o, 1'b0);
        drain();

        // Illegal requests (7 is legal only for single-round unrolling).
        issue(rand_state(), 5'd17, 1'b1);
        issue(rand_state(), 5'd7, 1'b1);
        drain();
        issue(rand_state(), 5'd31, 1'b1);
        drain();

        // Reset around round 5 of p12.
        issue(rand_state(), 5'd12, 1'b0);
        repeat (4) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        check("midrun reset state_o", state_o, '0);
        check("midrun reset busy", busy_o, 1'b0);
        check("midrun reset start_ready", start_ready_o, 1'b1);
        seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            seen = seen | out_valid_o;
        end
        check("no out_valid after reset", seen, 1'b0);

`ifdef ASCON_PERM_ABORT_EN
        // Abort around round 5 of p12.
        issue(rand_state(), 5'd12, 1'b0);
        repeat (4) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort state_o", state_o, '0);
        check("abort busy", busy_o, 1'b0);
        seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            seen = seen | out_valid_o;
        end
        check("no out_valid after abort", seen, 1'b0);

        // Abort in DONE coinciding with out_ready.
        ready_mode = 1;
        issue(rand_state(), 5'd6, 1'b1);
        guard = 0;
        while (!out_valid_o && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("done-abort out_valid", out_valid_o, 1'b1);
        ready_mode = 2;
        @(posedge clk);
        #2 abort_i = 1'b1;
        @(posedge clk);
        #2 abort_i = 1'b0;
        @(negedge clk);
        check("done-abort out_valid low", out_valid_o, 1'b0);
        check("done-abort state_o", state_o, '0);
        check("done-abort idle", start_ready_o, 1'b1);
        if (sb.size() != 0) void'(sb.pop_front());
`endif

        // Randomized traffic with random back-pressure.
        ready_mode = 0;
        for (int n = 0; n < 500; n++) begin
            logic [4:0] r;
            if ($urandom_range(0, 9) == 0) r = 5'($urandom_range(17, 31));
            else                           r = 5'($urandom_range(0, 16));
            issue(rand_state(), r, 1'b1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
